rr_grant_scheduler: RTL and testbench
=====================================

# rr_grant_scheduler

Four-way round-robin scheduler that shares a single resource between four requesters and drives a one-hot select bus, the 2-to-4 decoded form of its registered 2-bit winner index. It sits in front of the shared datapath and sequences ownership: one owner at a time, bounded hold time and fair rotation. All outputs are registered.

## Interface

- MAX_HOLD, default 8: maximum consecutive cycles one grant may be held; legal range 1 .. 2^CNT_W.
- CNT_W, default 4: width of the hold counter.

- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  request vector; bit i is requester i.
- done  input  1  current owner releases the resource; sampled only in GRANT.
- grant  output  4  one-hot grant: decode of grant_idx (00→0001, 01→0010, 10→0100, 11→1000) when grant_valid=1; 0000 otherwise.
- grant_idx  output  2  index of the current or last owner.
- grant_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

## Operation

- State machine: IDLE, GRANT.
- Round-robin pointer ptr (2 bits) = highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - If req≠0000: winner = first set bit in the search order. Next edge: grant_idx←winner, grant_valid←1, hold_cnt←0, state←GRANT.
  - If req=0000: stay in IDLE; ptr unchanged; done ignored.
- GRANT, evaluated each edge with hold_cnt incrementing by 1:
  - Release when done=1, or when req[grant_idx]=0 (requester withdrew), or when hold_cnt==MAX_HOLD-1.
  - On release: grant_valid←0, ptr←grant_idx+1 (wraps 3→0), state←IDLE. grant_idx keeps its value.
  - timeout←1 for one cycle only if the release was caused solely by hold_cnt==MAX_HOLD-1, with done=0 and req[grant_idx]=1 on that edge. If done or withdrawal coincides with the limit, there is no timeout pulse.
  - New requests arriving during GRANT never preempt the owner.
- Reset values, applied asynchronously as rst_n falls: grant=0000, grant_idx=00, grant_valid=0, timeout=0, ptr=00, hold_cnt=0, state=IDLE. Reset mid-grant drops grant immediately. After reset the first winner is searched from index 0.
- Invariant: grant has at most one bit set, and grant≠0000 exactly when grant_valid=1.

## Timing

- Request-to-grant latency: req sampled in IDLE at edge t → grant visible after edge t, i.e. one cycle.
- Hold: grant is high for at least 1 cycle and at most MAX_HOLD cycles.
- Release: done or withdrawal sampled at edge t → grant=0000 after edge t.
- Mandatory gap: one IDLE cycle between consecutive grants, even back-to-back to the same requester. Maximum throughput is one grant per 2 cycles.
- timeout is high in the first IDLE cycle after a forced release.
- MAX_HOLD=1: every grant lasts exactly 1 cycle. No timeout pulse is generated when done or withdrawal coincides with that cycle.

## Test plan

- Reset: hold rst_n=0 with req=1111. All outputs stay 0. Release reset. After the first edge: grant=0001, grant_idx=00, grant_valid=1.
- Rotation: req=1111 held, done=1 on each grant cycle. Grants run 0001, 0010, 0100, 1000, 0001, each separated by one grant=0000 cycle.
- Timeout: MAX_HOLD=8, req=0100 held, done=0. grant=0100 for exactly 8 cycles, then grant=0000 with timeout=1 for one cycle, then grant=0100 again.
- Withdrawal and fairness: grant=0010 active, req changes to 1001. Next edge: grant=0000, no timeout. Next: grant=1000, because ptr=2 and index 3 comes before index 0.
- Async reset mid-grant: grant=1000 active, rst_n pulsed low between edges. grant=0000 immediately, without waiting for an edge. After release with req=1111, grant=0001.
- Idle stability: req=0000 and done toggling for 10 cycles. Outputs stay 0 and ptr is unchanged. Then req=0100 gives grant=0100 one cycle later.

Source files
------------

// File: rtl/rr_grant_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_scheduler_if
// Description : Request/grant bundle between four requesters and the
//               round-robin scheduler that owns the shared resource.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_grant_scheduler_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  // Requester side: drives requests and release, observes the grant.
  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  // Scheduler side.
  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface
`default_nettype wire

// File: rtl/rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_scheduler
// Description : Four-way round-robin scheduler with bounded hold time.
//               One owner at a time, one idle cycle between grants, and a
//               timeout pulse when an owner is forced off by MAX_HOLD.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_scheduler #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_grant_scheduler_if.slave  bus
);

  localparam logic [0:0]       c_st_idle   = 1'b0;
  localparam logic [0:0]       c_st_grant  = 1'b1;
  // Last hold-counter value of a grant; MAX_HOLD <= 2^CNT_W keeps it in range.
  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [1:0]       r_grant_idx;
  logic             r_grant_valid;
  logic             r_timeout;
  logic [3:0]       r_grant;

  logic [0:0]       w_state_nxt;
  logic [1:0]       w_ptr_nxt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;
  logic [1:0]       w_grant_idx_nxt;
  logic             w_grant_valid_nxt;
  logic             w_timeout_nxt;
  logic [3:0]       w_grant_nxt;

  logic [1:0]       w_winner;
  logic             w_any_req;
  logic             w_limit;
  logic             w_owner_req;
  logic             w_release;

  // Pick the first requester at or after the pointer; scanning from the far
  // end lets the closest hit overwrite earlier ones without a found flag.
  always_comb begin
    w_winner = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[2'(r_ptr + 2'(k))]) begin
        w_winner = 2'(r_ptr + 2'(k));
      end
    end
  end

  assign w_any_req   = |bus.req;
  assign w_limit     = (r_hold_cnt == c_hold_last);
  assign w_owner_req = bus.req[r_grant_idx];
  assign w_release   = bus.done | ~w_owner_req | w_limit;

  // State register and all registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_st_idle;
      r_ptr         <= 2'd0;
      r_hold_cnt    <= '0;
      r_grant_idx   <= 2'd0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_grant       <= 4'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_timeout     <= w_timeout_nxt;
      r_grant       <= w_grant_nxt;
    end
  end

  // Next state: grant on any request, return to idle on any release cause.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_any_req) w_state_nxt = c_st_grant;
      c_st_grant: if (w_release) w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // Next register values for pointer, counter and outputs.
  always_comb begin
    w_ptr_nxt         = r_ptr;
    w_hold_cnt_nxt    = r_hold_cnt;
    w_grant_idx_nxt   = r_grant_idx;
    w_grant_valid_nxt = r_grant_valid;
    w_timeout_nxt     = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_any_req) begin
          w_grant_idx_nxt   = w_winner;
          w_grant_valid_nxt = 1'b1;
          w_hold_cnt_nxt    = '0;
        end
      end
      c_st_grant: begin
        if (w_release) begin
          w_grant_valid_nxt = 1'b0;
          w_ptr_nxt         = r_grant_idx + 2'd1;
          // Only a pure hold-limit release counts as a timeout.
          w_timeout_nxt     = w_limit & ~bus.done & w_owner_req;
        end else begin
          w_hold_cnt_nxt    = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_grant_valid_nxt = 1'b0;
      end
    endcase
    w_grant_nxt = w_grant_valid_nxt ? (4'b0001 << w_grant_idx_nxt) : 4'b0000;
  end

  assign bus.grant       = r_grant;
  assign bus.grant_idx   = r_grant_idx;
  assign bus.grant_valid = r_grant_valid;
  assign bus.timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_grant_scheduler
// Description : Self-checking bench for rr_grant_scheduler; a cycle model of
//               ownership, hold length and rotation is compared every cycle,
//               alongside hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_scheduler;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  rr_grant_scheduler_if bus_if ();

  rr_grant_scheduler #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: current owner (-1 when none), last owner, cycles the owner
  // has held the grant so far, priority pointer and pending timeout flag.
  int   m_owner;
  int   m_last;
  int   m_held;
  int   m_ptr;
  logic m_to;

  function automatic int first_from(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Ownership model advanced at every edge from the sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= 0;
      m_held  <= 0;
      m_ptr   <= 0;
      m_to    <= 1'b0;
    end else if (m_owner < 0) begin
      m_to <= 1'b0;
      if (bus_if.req != 4'd0) begin
        m_owner <= first_from(m_ptr, bus_if.req);
        m_last  <= first_from(m_ptr, bus_if.req);
        m_held  <= 1;
      end
    end else if (bus_if.done || !bus_if.req[m_owner] || m_held == MAX_HOLD) begin
      m_to    <= (m_held == MAX_HOLD) && !bus_if.done && bus_if.req[m_owner];
      m_owner <= -1;
      m_ptr   <= (m_owner + 1) % 4;
    end else begin
      m_held <= m_held + 1;
      m_to   <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to the falling edge and compare every output against the model.
  task automatic tick();
    logic [3:0] eg;
    @(negedge clk);
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    chk("model_grant",       bus_if.grant,              eg);
    chk("model_grant_idx",   {2'b00, bus_if.grant_idx}, 4'(m_last));
    chk("model_grant_valid", {3'b000, bus_if.grant_valid}, {3'b000, m_owner >= 0});
    chk("model_timeout",     {3'b000, bus_if.timeout},  {3'b000, m_to});
  endtask

  logic [3:0] rot [8];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rot = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

    // Reset held with all requests active.
    rst_n          = 1'b0;
    bus_if.req     = 4'b1111;
    bus_if.done    = 1'b0;
    tick();
    tick();
    chk("reset_grant", bus_if.grant, 4'b0000);
    chk("reset_valid", {3'b000, bus_if.grant_valid}, 4'd0);
    rst_n = 1'b1;
    tick();
    chk("first_grant", bus_if.grant, 4'b0001);
    chk("first_idx",   {2'b00, bus_if.grant_idx}, 4'd0);
    chk("first_valid", {3'b000, bus_if.grant_valid}, 4'd1);

    // Rotation with done on every grant cycle.
    bus_if.done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rotation", bus_if.grant, rot[i]);
    end

    // Owner 0 withdraws; then requester 2 holds until the limit.
    bus_if.done = 1'b0;
    bus_if.req  = 4'b0100;
    tick();
    chk("withdraw0_grant", bus_if.grant, 4'b0000);
    chk("withdraw0_to",    {3'b000, bus_if.timeout}, 4'd0);
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick();
      chk("hold_grant", bus_if.grant, 4'b0100);
    end
    tick();
    chk("timeout_grant", bus_if.grant, 4'b0000);
    chk("timeout_pulse", {3'b000, bus_if.timeout}, 4'd1);
    tick();
    chk("regrant_grant", bus_if.grant, 4'b0100);
    chk("regrant_to",    {3'b000, bus_if.timeout}, 4'd0);

    // Move ownership to requester 1 (pointer becomes 3 after owner 2).
    bus_if.req  = 4'b0010;
    bus_if.done = 1'b1;
    tick();
    chk("rel2_grant", bus_if.grant, 4'b0000);
    bus_if.done = 1'b0;
    tick();
    chk("own1_grant", bus_if.grant, 4'b0010);

    // Withdrawal and fairness: pointer 2 gives index 3 before index 0.
    bus_if.req = 4'b1001;
    tick();
    chk("wd1_grant", bus_if.grant, 4'b0000);
    chk("wd1_to",    {3'b000, bus_if.timeout}, 4'd0);
    tick();
    chk("fair_grant", bus_if.grant, 4'b1000);
    chk("fair_idx",   {2'b00, bus_if.grant_idx}, 4'd3);

    // Asynchronous reset between edges drops the grant at once.
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", bus_if.grant, 4'b0000);
    chk("async_valid", {3'b000, bus_if.grant_valid}, 4'd0);
    chk("async_idx",   {2'b00, bus_if.grant_idx}, 4'd0);
    tick();
    bus_if.req = 4'b1111;
    rst_n      = 1'b1;
    tick();
    chk("post_reset_grant", bus_if.grant, 4'b0001);

    // Idle stability with done toggling; pointer left at 1 by owner 0.
    bus_if.req = 4'b0000;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus_if.done = ~bus_if.done;
      tick();
      chk("idle_grant", bus_if.grant, 4'b0000);
    end
    bus_if.done = 1'b0;
    bus_if.req  = 4'b0100;
    tick();
    chk("idle_exit_grant", bus_if.grant, 4'b0100);

    // done coinciding with the hold limit: release without timeout.
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      tick();
    end
    chk("limit_last_grant", bus_if.grant, 4'b0100);
    bus_if.done = 1'b1;
    tick();
    chk("limit_done_grant", bus_if.grant, 4'b0000);
    chk("limit_done_to",    {3'b000, bus_if.timeout}, 4'd0);
    bus_if.done = 1'b0;
    bus_if.req  = 4'b0000;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
